// File: rtl/uart_block_tx.sv
//------------------------------------------------------------------------------
// Module      : uart_block_tx
// Description : UART transmitter that sends a multi-byte block (e.g. an AES
//               ciphertext) as back-to-back asynchronous frames. Each frame has
//               a start bit, DATA_BITS data bits sent LSB first, an optional
//               parity bit and STOP_BITS stop bits. Reports block completion
//               with a one-cycle done pulse.
//               Optional feature macro: UART_TX_PARITY_EN (parity bit after
//               the data bits; sense chosen by PARITY_ODD).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_block_tx #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int BLOCK_BYTES = 16,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BLOCK_BYTES*8-1:0]     data,
  input  logic                         abort,
  output logic                         tx,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(BLOCK_BYTES):0] byte_idx
);

  //----------------------------------------------------------------------------
  // Derived constants
  //----------------------------------------------------------------------------
  localparam int c_BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int c_CNT_W      = (c_BIT_PERIOD > 1) ? $clog2(c_BIT_PERIOD) : 1;
  localparam int c_IDX_W      = $clog2(BLOCK_BYTES) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_BIT_PERIOD - 1);
  localparam logic [2:0]         c_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(BLOCK_BYTES - 1);

  // State encoding
  localparam int         c_ST_W   = 3;
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd4;
`endif

  //----------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  //----------------------------------------------------------------------------
  if (c_BIT_PERIOD < 2) begin : g_chk_bit_period
    $error("uart_block_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if (BLOCK_BYTES < 1 || BLOCK_BYTES > 32) begin : g_chk_block_bytes
    $error("uart_block_tx: BLOCK_BYTES must be in 1..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
    $error("uart_block_tx: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
    $error("uart_block_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_parity_odd
    $error("uart_block_tx: PARITY_ODD must be 0 or 1");
  end

  //----------------------------------------------------------------------------
  // Registers and wires
  //----------------------------------------------------------------------------
  logic [c_ST_W-1:0]        r_state;
  logic [c_ST_W-1:0]        w_state_next;
  logic [c_CNT_W-1:0]       r_baud_cnt;
  logic [c_CNT_W-1:0]       w_baud_next;
  logic [2:0]               r_bit_cnt;     // data bit or stop bit index in the current state
  logic [2:0]               w_bit_next;
  logic [c_IDX_W-1:0]       r_byte_idx;
  logic [BLOCK_BYTES*8-1:0] r_buf;         // latched block; byte on the line sits in [7:0]
  logic                     r_tx;
  logic                     r_done;
  logic                     w_tx_next;
  logic                     w_done_next;
  logic                     w_frame_adv;
  logic                     w_bit_end;
  logic                     w_accept;
  logic                     w_abort;
  logic                     w_last_data;
  logic                     w_last_stop;
  logic                     w_last_byte;
  logic [7:0]               w_cur_byte;

  assign w_cur_byte  = r_buf[7:0];
  assign w_bit_end   = (r_baud_cnt == c_CNT_LAST);
  assign w_last_data = (r_bit_cnt == c_DATA_LAST);
  assign w_last_stop = (r_bit_cnt == c_STOP_LAST);
  assign w_last_byte = (r_byte_idx == c_IDX_LAST);

  // A start is refused while the completion pulse of the previous block is
  // still showing, and abort always beats start.
  assign w_accept = (r_state == c_IDLE) && start && !abort && !r_done;
  assign w_abort  = abort && (r_state != c_IDLE);

`ifdef UART_TX_PARITY_EN
  logic w_parity;
  assign w_parity = (^w_cur_byte[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif

  //----------------------------------------------------------------------------
  // FSM state register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  //----------------------------------------------------------------------------
  // Next-state logic; abort overrides any bit-boundary transition
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) w_state_next = c_START;
        end
        c_START: begin
          if (w_bit_end) w_state_next = c_DATA;
        end
        c_DATA: begin
          if (w_bit_end && w_last_data) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = c_PARITY;
`else
            w_state_next = c_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        c_PARITY: begin
          if (w_bit_end) w_state_next = c_STOP;
        end
`endif
        c_STOP: begin
          if (w_bit_end && w_last_stop) begin
            w_state_next = w_last_byte ? c_IDLE : c_START;
          end
        end
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Output / datapath decode: next counter values, next line level, done pulse
  //----------------------------------------------------------------------------
  always_comb begin
    // Baud counter restarts at every bit boundary and is parked at zero while
    // idle, so every frame starts on a fresh full bit period.
    w_baud_next = r_baud_cnt + 1'b1;
    if ((r_state == c_IDLE) || (w_state_next == c_IDLE) || w_bit_end) begin
      w_baud_next = '0;
    end

    // Bit index restarts on every state change and steps at bit boundaries
    w_bit_next = r_bit_cnt;
    if (w_state_next != r_state) begin
      w_bit_next = '0;
    end else if (w_bit_end) begin
      w_bit_next = r_bit_cnt + 3'd1;
    end

    w_frame_adv = (r_state == c_STOP) && (w_state_next == c_START);
    w_done_next = (r_state == c_STOP) && (w_state_next == c_IDLE) && !w_abort;

    // tx is registered, so it is driven from the level of the upcoming state
    case (w_state_next)
      c_START:  w_tx_next = 1'b0;
      c_DATA:   w_tx_next = w_cur_byte[w_bit_next];
`ifdef UART_TX_PARITY_EN
      c_PARITY: w_tx_next = w_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  //----------------------------------------------------------------------------
  // Datapath registers: counters, byte buffer, line and done pulse
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_buf      <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_baud_cnt <= w_baud_next;
      r_bit_cnt  <= w_bit_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;

      if (w_state_next == c_IDLE) begin
        r_byte_idx <= '0;
      end else if (w_frame_adv) begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end

      // Block is captured once; later changes on data are not seen
      if (w_accept) begin
        r_buf <= data;
      end else if (w_frame_adv) begin
        r_buf <= r_buf >> 8;
      end
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != c_IDLE);
  assign done     = r_done;
  assign byte_idx = r_byte_idx;

endmodule

`default_nettype wire
